fb_scaler: RTL

Display-side scan-out stage between the 160x120 3-bit framebuffer (menu pROM / game pixel store) and the `hdmi` encoder. It consumes the encoder's `cx`/`cy` raster coordinates and generates framebuffer read addresses with 4x pixel and line replication, using counters rather than multipliers. It expands the returned 3-bit `{R,G,B}` code to 24-bit RGB and delivers `rgb`/`de` pipeline-aligned, with a fixed, documented latency.

---
 rtl/video_pkg.sv | 21 ++
 rtl/fb_scaler_addrgen.sv | 99 +++++++++
 rtl/fb_scaler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared pixel types, default raster geometry and the 3-bit palette
// used by the framebuffer scan-out path.
package video_pkg;

   typedef logic [23:0] rgb24_t;
   typedef logic [2:0]  pix3_t;

   // Source framebuffer and 640x480@60 raster geometry
   localparam int SRC_W   = 160;
   localparam int SRC_H   = 120;
   localparam int ACT_W   = 640;
   localparam int ACT_H   = 480;
   localparam int FRAME_W = 800;
   localparam int FRAME_H = 525;

   // Each code bit drives one full colour channel: bit2 -> R, bit1 -> G, bit0 -> B
   function automatic rgb24_t pal3_to_rgb24(input pix3_t code);
      return {{8{code[2]}}, {8{code[1]}}, {8{code[0]}}};
   endfunction

endpackage

// File: rtl/fb_scaler_addrgen.sv
// fb_scaler_addrgen: turns the encoder's cx/cy raster position into framebuffer
// read addresses with (1<<SCALE_LOG2)x pixel and line replication. Counters only,
// no multipliers. Locks to the raster on the first origin after reset and
// re-locks on every origin.
module fb_scaler_addrgen
   import video_pkg::*;
#(
   parameter int SRC_W      = video_pkg::SRC_W,
   parameter int SRC_H      = video_pkg::SRC_H,
   parameter int SCALE_LOG2 = 2,
   parameter int ACT_W      = video_pkg::ACT_W,
   parameter int ACT_H      = video_pkg::ACT_H,
   parameter int ADDR_W     = 15
) (
   input  logic              clk_pixel,
   input  logic              sys_resetn,
   input  logic [9:0]        cx,
   input  logic [9:0]        cy,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_rd_en,
   output logic              frame_tick
);

   localparam logic [9:0]            X_END    = 10'(ACT_W);
   localparam logic [9:0]            Y_END    = 10'(ACT_H);
   localparam logic [9:0]            X_LAST   = 10'(ACT_W - 1);
   localparam logic [ADDR_W-1:0]     ROW_STEP = ADDR_W'(SRC_W);
   localparam logic [ADDR_W-1:0]     ROW_LAST = ADDR_W'((SRC_H - 1) * SRC_W);
   localparam logic [ADDR_W-1:0]     ADDR_ONE = 1;
   localparam logic [SCALE_LOG2-1:0] SUB_ONE  = 1;

   logic                  synced;
   logic [ADDR_W-1:0]     row_base;
   logic [ADDR_W-1:0]     col_addr;
   logic [SCALE_LOG2-1:0] sub_row;
   logic [SCALE_LOG2-1:0] sub_col;

   logic                  origin_p0;
   logic                  active_p0;
   logic                  line_end_p0;
   logic                  issue_p0;
   logic [ADDR_W-1:0]     row_base_p0;
   logic [ADDR_W-1:0]     col_addr_p0;
   logic [SCALE_LOG2-1:0] sub_row_p0;
   logic [SCALE_LOG2-1:0] sub_col_p0;

   // ---- stage p0: decode the raster position; the origin overrides the counters
   assign origin_p0   = (cx == '0) && (cy == '0);
   assign active_p0   = (cx < X_END) && (cy < Y_END);
   assign line_end_p0 = (cx == X_LAST);
   assign issue_p0    = (synced | origin_p0) & active_p0;

   assign row_base_p0 = origin_p0 ? '0 : row_base;
   assign col_addr_p0 = origin_p0 ? '0 : col_addr;
   assign sub_row_p0  = origin_p0 ? '0 : sub_row;
   assign sub_col_p0  = origin_p0 ? '0 : sub_col;

   // ---- stage p1: registered address/enable/tick and the replication counters
   always_ff @(posedge clk_pixel or negedge sys_resetn) begin
      if (!sys_resetn) begin
         synced     <= 1'b0;
         row_base   <= '0;
         col_addr   <= '0;
         sub_row    <= '0;
         sub_col    <= '0;
         fb_addr    <= '0;
         fb_rd_en   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= origin_p0;
         fb_rd_en   <= issue_p0;
         if (origin_p0) begin
            synced <= 1'b1;
         end
         if (issue_p0) begin
            fb_addr <= row_base_p0 + col_addr_p0;
            if (line_end_p0) begin
               // End of an active line: restart the column and step the line counter
               col_addr <= '0;
               sub_col  <= '0;
               sub_row  <= sub_row_p0 + SUB_ONE;
               if (&sub_row_p0) begin
                  // Last replica of a source row; wrap after the final row so the
                  // base never points past the framebuffer
                  row_base <= (row_base_p0 == ROW_LAST) ? '0 : row_base_p0 + ROW_STEP;
               end else begin
                  row_base <= row_base_p0;
               end
            end else begin
               sub_col  <= sub_col_p0 + SUB_ONE;
               col_addr <= (&sub_col_p0) ? col_addr_p0 + ADDR_ONE : col_addr_p0;
               sub_row  <= sub_row_p0;
               row_base <= row_base_p0;
            end
         end
      end
   end

endmodule

// File: rtl/fb_scaler.sv
// fb_scaler: scan-out stage from the 160x120 3-bit framebuffer to the hdmi
// encoder. Address generation lives in fb_scaler_addrgen; this level carries
// the valid/border delay line matched to the memory latency and registers the
// expanded 24-bit pixel. Latency cx/cy -> rgb/de is MEM_LAT+2 cycles.
// Build option: define FB_SCALER_BORDER_EN to paint the outermost active
// pixels white (24'hFFFFFF); without it no border logic exists.
module fb_scaler
   import video_pkg::*;
#(
   parameter int SRC_W      = video_pkg::SRC_W,
   parameter int SRC_H      = video_pkg::SRC_H,
   parameter int SCALE_LOG2 = 2,
   parameter int ACT_W      = video_pkg::ACT_W,
   parameter int ACT_H      = video_pkg::ACT_H,
   parameter int FRAME_W    = video_pkg::FRAME_W,
   parameter int FRAME_H    = video_pkg::FRAME_H,
   parameter int MEM_LAT    = 1,
   parameter int ADDR_W     = 15
) (
   input  logic              clk_pixel,
   input  logic              sys_resetn,
   input  logic [9:0]        cx,
   input  logic [9:0]        cy,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_rd_en,
   input  pix3_t             fb_data,
   output rgb24_t            rgb,
   output logic              de,
   output logic              frame_tick
);

   // Reject geometries the counter scheme cannot represent
   if ((ACT_W != (SRC_W << SCALE_LOG2)) || (ACT_H != (SRC_H << SCALE_LOG2)) ||
       (FRAME_W <= ACT_W) || (FRAME_H <= ACT_H) ||
       (MEM_LAT < 1) || (MEM_LAT > 2) || (SCALE_LOG2 < 1)) begin : g_bad_cfg
      $error("fb_scaler: inconsistent geometry or MEM_LAT parameters");
   end

   fb_scaler_addrgen #(
      .SRC_W      (SRC_W),
      .SRC_H      (SRC_H),
      .SCALE_LOG2 (SCALE_LOG2),
      .ACT_W      (ACT_W),
      .ACT_H      (ACT_H),
      .ADDR_W     (ADDR_W)
   ) u_addrgen (
      .clk_pixel  (clk_pixel),
      .sys_resetn (sys_resetn),
      .cx         (cx),
      .cy         (cy),
      .fb_addr    (fb_addr),
      .fb_rd_en   (fb_rd_en),
      .frame_tick (frame_tick)
   );

   // ---- stage p1 -> p(1+MEM_LAT): valid follows the read through the memory
   logic [MEM_LAT-1:0] vld_dly;
   logic [MEM_LAT:0]   vld_shift;
   logic               vld_pm;
   rgb24_t             rgb_pm;

   assign vld_shift = {vld_dly, fb_rd_en};
   assign vld_pm    = vld_dly[MEM_LAT-1];

   // Valid delay line matched to the framebuffer read latency
   always_ff @(posedge clk_pixel or negedge sys_resetn) begin
      if (!sys_resetn) begin
         vld_dly <= '0;
      end else begin
         vld_dly <= vld_shift[MEM_LAT-1:0];
      end
   end

`ifdef FB_SCALER_BORDER_EN
   localparam logic [9:0] X_LAST = 10'(ACT_W - 1);
   localparam logic [9:0] Y_LAST = 10'(ACT_H - 1);

   logic               border_p0;
   logic               border_p1;
   logic [MEM_LAT-1:0] border_dly;
   logic [MEM_LAT:0]   border_shift;

   assign border_p0    = (cx == '0) || (cx == X_LAST) || (cy == '0) || (cy == Y_LAST);
   assign border_shift = {border_dly, border_p1};

   // Border flag rides alongside the read: one register, then MEM_LAT stages
   always_ff @(posedge clk_pixel or negedge sys_resetn) begin
      if (!sys_resetn) begin
         border_p1  <= 1'b0;
         border_dly <= '0;
      end else begin
         border_p1  <= border_p0;
         border_dly <= border_shift[MEM_LAT-1:0];
      end
   end

   // Palette expansion with the border overriding the framebuffer colour
   always_comb begin
      rgb_pm = pal3_to_rgb24(fb_data);
      if (border_dly[MEM_LAT-1]) begin
         rgb_pm = 24'hFFFFFF;
      end
   end
`else
   // Palette expansion of the returned framebuffer code
   always_comb begin
      rgb_pm = pal3_to_rgb24(fb_data);
   end
`endif

   // ---- stage p(2+MEM_LAT): output register, dark whenever the pixel is not valid
   always_ff @(posedge clk_pixel or negedge sys_resetn) begin
      if (!sys_resetn) begin
         rgb <= '0;
         de  <= 1'b0;
      end else begin
         de  <= vld_pm;
         rgb <= vld_pm ? rgb_pm : '0;
      end
   end

endmodule
